// File: rtl/rsa_job_sequencer_if.sv
// Job request, response and RSA control-block signals of rsa_job_sequencer.
// The rsp_mismatch signal exists only when RSA_ROUNDTRIP_CHECK_EN is defined.
interface rsa_job_sequencer_if #(
  parameter int WIDTH = 128
);
  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     req_p;
  logic [WIDTH-1:0]     req_q;
  logic                 req_mode;
  logic [2*WIDTH-1:0]   req_msg;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2*WIDTH-1:0]   rsp_msg;
  logic                 rsp_timeout;
`ifdef RSA_ROUNDTRIP_CHECK_EN
  logic                 rsp_mismatch;
`endif

  logic [WIDTH-1:0]     ctl_p;
  logic [WIDTH-1:0]     ctl_q;
  logic                 ctl_encrypt_decrypt;
  logic [2*WIDTH-1:0]   ctl_msg_in;
  logic                 ctl_reset_inverter;
  logic                 ctl_reset_mod_exp;
  logic                 ctl_inverter_finish;
  logic                 ctl_mod_exp_finish;
  logic [2*WIDTH-1:0]   ctl_msg_out;

  modport slave (
    input  req_valid, req_p, req_q, req_mode, req_msg,
    output req_ready,
    input  rsp_ready,
    output rsp_valid, rsp_msg, rsp_timeout,
    output ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in,
    output ctl_reset_inverter, ctl_reset_mod_exp,
    input  ctl_inverter_finish, ctl_mod_exp_finish, ctl_msg_out
`ifdef RSA_ROUNDTRIP_CHECK_EN
    , output rsp_mismatch
`endif
  );

  modport master (
    output req_valid, req_p, req_q, req_mode, req_msg,
    input  req_ready,
    output rsp_ready,
    input  rsp_valid, rsp_msg, rsp_timeout,
    input  ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in,
    input  ctl_reset_inverter, ctl_reset_mod_exp,
    output ctl_inverter_finish, ctl_mod_exp_finish, ctl_msg_out
`ifdef RSA_ROUNDTRIP_CHECK_EN
    , input rsp_mismatch
`endif
  );
endinterface

// File: rtl/rsa_job_sequencer.sv
// Runs one RSA job through the control block (inverter, then mod-exp) with per-phase timeout.
// Define RSA_ROUNDTRIP_CHECK_EN to add a reverse pass that flags rsp_mismatch.
module rsa_job_sequencer #(
  parameter int          WIDTH          = 128,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                clk,
  input logic                rst_n,
  rsa_job_sequencer_if.slave bus
);
  localparam int MSG_W = 2 * WIDTH;

  typedef enum logic [3:0] {
    IDLE,
    INV_PULSE,
    INV_WAIT,
    EXP_PULSE,
    EXP_WAIT,
    RESP
`ifdef RSA_ROUNDTRIP_CHECK_EN
    , CHK_INV_PULSE,
    CHK_INV_WAIT,
    CHK_EXP_PULSE,
    CHK_EXP_WAIT
`endif
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [31:0]        wait_cnt;
  logic [WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]   q_r;
  logic               mode_r;
  logic [MSG_W-1:0]   msg_in_r;
  logic [MSG_W-1:0]   rsp_msg_r;
  logic               timeout_r;
`ifdef RSA_ROUNDTRIP_CHECK_EN
  logic [MSG_W-1:0]   orig_msg;
  logic               mismatch_r;
`endif

  logic in_wait;
  logic in_pulse;
  logic finish_sel;
  logic finish_ok;
  logic timeout_hit;
  logic accept;
  logic capture;
  logic pulse_inv;
  logic pulse_exp;

  always_comb begin
    state_n    = state;
    in_wait    = 1'b0;
    in_pulse   = 1'b0;
    finish_sel = 1'b0;
    pulse_inv  = 1'b0;
    pulse_exp  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;

    case (state)
      INV_PULSE:     begin in_pulse = 1'b1; pulse_inv = 1'b1; end
      EXP_PULSE:     begin in_pulse = 1'b1; pulse_exp = 1'b1; end
      INV_WAIT:      begin in_wait = 1'b1; finish_sel = bus.ctl_inverter_finish; end
      EXP_WAIT:      begin in_wait = 1'b1; finish_sel = bus.ctl_mod_exp_finish; end
`ifdef RSA_ROUNDTRIP_CHECK_EN
      CHK_INV_PULSE: begin in_pulse = 1'b1; pulse_inv = 1'b1; end
      CHK_EXP_PULSE: begin in_pulse = 1'b1; pulse_exp = 1'b1; end
      CHK_INV_WAIT:  begin in_wait = 1'b1; finish_sel = bus.ctl_inverter_finish; end
      CHK_EXP_WAIT:  begin in_wait = 1'b1; finish_sel = bus.ctl_mod_exp_finish; end
`endif
      default: ;
    endcase

    // wait_cnt is zero only in the first wait cycle, where a finish left over from before is ignored
    finish_ok   = in_wait && (wait_cnt != 32'd0) && finish_sel;
    timeout_hit = in_wait && !finish_ok && (wait_cnt >= TIMEOUT_CYCLES);

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_n = INV_PULSE;
        end
      end
      INV_PULSE: state_n = INV_WAIT;
      INV_WAIT: begin
        if (finish_ok)        state_n = EXP_PULSE;
        else if (timeout_hit) state_n = RESP;
      end
      EXP_PULSE: state_n = EXP_WAIT;
      EXP_WAIT: begin
        if (finish_ok) begin
          capture = 1'b1;
`ifdef RSA_ROUNDTRIP_CHECK_EN
          state_n = CHK_INV_PULSE;
`else
          state_n = RESP;
`endif
        end else if (timeout_hit) begin
          state_n = RESP;
        end
      end
`ifdef RSA_ROUNDTRIP_CHECK_EN
      CHK_INV_PULSE: state_n = CHK_INV_WAIT;
      CHK_INV_WAIT: begin
        if (finish_ok)        state_n = CHK_EXP_PULSE;
        else if (timeout_hit) state_n = RESP;
      end
      CHK_EXP_PULSE: state_n = CHK_EXP_WAIT;
      CHK_EXP_WAIT: begin
        if (finish_ok || timeout_hit) state_n = RESP;
      end
`endif
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 32'd0;
      p_r        <= '0;
      q_r        <= '0;
      mode_r     <= 1'b0;
      msg_in_r   <= '0;
      rsp_msg_r  <= '0;
      timeout_r  <= 1'b0;
`ifdef RSA_ROUNDTRIP_CHECK_EN
      orig_msg   <= '0;
      mismatch_r <= 1'b0;
`endif
    end else begin
      state <= state_n;

      if (in_pulse)     wait_cnt <= 32'd0;
      else if (in_wait) wait_cnt <= wait_cnt + 32'd1;

      if (accept) begin
        p_r       <= bus.req_p;
        q_r       <= bus.req_q;
        mode_r    <= bus.req_mode;
        msg_in_r  <= bus.req_msg;
        rsp_msg_r <= '0;
        timeout_r <= 1'b0;
`ifdef RSA_ROUNDTRIP_CHECK_EN
        orig_msg   <= bus.req_msg;
        mismatch_r <= 1'b0;
`endif
      end

      if (capture) begin
        rsp_msg_r <= bus.ctl_msg_out;
`ifdef RSA_ROUNDTRIP_CHECK_EN
        // reverse pass: feed the result back with the opposite direction
        msg_in_r  <= bus.ctl_msg_out;
        mode_r    <= ~mode_r;
`endif
      end

`ifdef RSA_ROUNDTRIP_CHECK_EN
      if ((state == CHK_EXP_WAIT) && finish_ok)
        mismatch_r <= (bus.ctl_msg_out != orig_msg);
`endif

      if (timeout_hit) begin
        timeout_r <= 1'b1;
        rsp_msg_r <= '0;
      end
    end
  end

  assign bus.req_ready           = (state == IDLE);
  assign bus.rsp_valid           = (state == RESP);
  assign bus.rsp_msg             = rsp_msg_r;
  assign bus.rsp_timeout         = timeout_r;
  assign bus.ctl_p               = p_r;
  assign bus.ctl_q               = q_r;
  assign bus.ctl_encrypt_decrypt = mode_r;
  assign bus.ctl_msg_in          = msg_in_r;
  assign bus.ctl_reset_inverter  = pulse_inv;
  assign bus.ctl_reset_mod_exp   = pulse_exp;
`ifdef RSA_ROUNDTRIP_CHECK_EN
  assign bus.rsp_mismatch        = mismatch_r;
`endif

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Bench for rsa_job_sequencer: table vectors, random jobs against a reference model, and
// hand-written sequences for stale finish and mid-job reset.
`timescale 1ns/1ps
module tb_rsa_job_sequencer;
  localparam int W  = 128;
  localparam int MW = 2 * W;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rsa_job_sequencer_if #(.WIDTH(W)) bus ();
  rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stand-in transform for the RSA core: encrypt adds {p,q}, decrypt subtracts it.
  function automatic logic [MW-1:0] ref_f(input logic [W-1:0] p, input logic [W-1:0] q,
                                          input logic mode, input logic [MW-1:0] m);
    return mode ? (m - {p, q}) : (m + {p, q});
  endfunction

  // Control-block model: finish rises d cycles after the earliest useful point; d<0 means never.
  int              inv_delay = 0;
  int              exp_delay = 0;
  bit              corrupt   = 1'b0;
  bit              manual    = 1'b0;
  logic            man_inv   = 1'b0;
  logic            man_exp   = 1'b0;
  logic [MW-1:0]   man_msg   = '0;
  logic            m_inv     = 1'b0;
  logic            m_exp     = 1'b0;
  logic [MW-1:0]   m_out     = '0;
  int              inv_cnt   = 0;
  int              exp_cnt   = 0;
  bit              inv_busy  = 1'b0;
  bit              exp_busy  = 1'b0;
  int              exp_pass  = 0;
  logic [W-1:0]    sp = '0, sq = '0;
  logic            smode = 1'b0;
  logic [MW-1:0]   smsg = '0;

  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) exp_pass <= 0;
    if (bus.ctl_reset_inverter) begin
      m_inv    <= 1'b0;
      inv_busy <= (inv_delay >= 0);
      inv_cnt  <= inv_delay + 1;
    end else if (inv_busy) begin
      if (inv_cnt == 1) begin m_inv <= 1'b1; inv_busy <= 1'b0; end
      else inv_cnt <= inv_cnt - 1;
    end
    if (bus.ctl_reset_mod_exp) begin
      m_exp    <= 1'b0;
      m_out    <= {8{$urandom}};
      exp_busy <= (exp_delay >= 0);
      exp_cnt  <= exp_delay + 1;
      sp <= bus.ctl_p; sq <= bus.ctl_q; smode <= bus.ctl_encrypt_decrypt; smsg <= bus.ctl_msg_in;
      exp_pass <= exp_pass + 1;
    end else if (exp_busy) begin
      if (exp_cnt == 1) begin
        m_exp    <= 1'b1;
        exp_busy <= 1'b0;
        m_out    <= ref_f(sp, sq, smode, smsg) ^ MW'((corrupt && exp_pass == 2) ? 1 : 0);
      end else exp_cnt <= exp_cnt - 1;
    end
  end

  always_comb begin
    bus.ctl_inverter_finish = manual ? man_inv : m_inv;
    bus.ctl_mod_exp_finish  = manual ? man_exp : m_exp;
    bus.ctl_msg_out         = manual ? man_msg : m_out;
  end

  // Pulse counts per job; a pulse longer than one cycle counts more than once.
  int n_inv = 0;
  int n_exp = 0;
  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      n_inv <= 0;
      n_exp <= 0;
    end else begin
      if (bus.ctl_reset_inverter) n_inv <= n_inv + 1;
      if (bus.ctl_reset_mod_exp)  n_exp <= n_exp + 1;
    end
  end

  typedef struct {
    logic [W-1:0]  p;
    logic [W-1:0]  q;
    logic          mode;
    logic [MW-1:0] msg;
    int            d_inv;
    int            d_exp;
    bit            corrupt;
    logic [MW-1:0] exp_msg;
    logic          exp_to;
    int            lat;
    int            n_inv;
    int            n_exp;
    int            lat_c;
    int            n_inv_c;
    int            n_exp_c;
    logic          mm_c;
  } vec_t;

  task automatic run_job(input vec_t v, input int hold);
    int lat, lat_e, ni_e, ne_e;
`ifdef RSA_ROUNDTRIP_CHECK_EN
    lat_e = v.lat_c; ni_e = v.n_inv_c; ne_e = v.n_exp_c;
`else
    lat_e = v.lat;   ni_e = v.n_inv;   ne_e = v.n_exp;
`endif
    inv_delay = v.d_inv;
    exp_delay = v.d_exp;
    corrupt   = v.corrupt;
    @(negedge clk);
    chk1("req_ready idle", bus.req_ready, 1'b1);
    chk1("rsp_valid idle", bus.rsp_valid, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_p = v.p; bus.req_q = v.q; bus.req_mode = v.mode; bus.req_msg = v.msg;
    @(posedge clk);
    @(negedge clk);
    // keep req_valid high with different data: it must be ignored while busy
    bus.req_p = ~v.p; bus.req_q = ~v.q; bus.req_mode = ~v.mode; bus.req_msg = ~v.msg;
    chkw("ctl_p", {{W{1'b0}}, bus.ctl_p}, {{W{1'b0}}, v.p});
    chkw("ctl_q", {{W{1'b0}}, bus.ctl_q}, {{W{1'b0}}, v.q});
    chkw("ctl_msg_in", bus.ctl_msg_in, v.msg);
    chk1("ctl_encrypt_decrypt", bus.ctl_encrypt_decrypt, v.mode);
    chk1("req_ready busy", bus.req_ready, 1'b0);
    lat = 0;
    while (!bus.rsp_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chki("latency", lat, lat_e);
    chk1("rsp_timeout", bus.rsp_timeout, v.exp_to);
    chkw("rsp_msg", bus.rsp_msg, v.exp_msg);
`ifdef RSA_ROUNDTRIP_CHECK_EN
    chk1("rsp_mismatch", bus.rsp_mismatch, v.mm_c);
`endif
    chki("inverter pulses", n_inv, ni_e);
    chki("mod_exp pulses", n_exp, ne_e);
    chkw("ctl_p held", {{W{1'b0}}, bus.ctl_p}, {{W{1'b0}}, v.p});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk1("rsp_valid hold", bus.rsp_valid, 1'b1);
      chkw("rsp_msg hold", bus.rsp_msg, v.exp_msg);
      chk1("req_ready hold", bus.req_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk1("rsp_valid after handshake", bus.rsp_valid, 1'b0);
    chk1("req_ready after handshake", bus.req_ready, 1'b1);
  endtask

  localparam logic [W-1:0]  P0 = 128'd113680897410347;
  localparam logic [W-1:0]  Q0 = 128'd7999808077935876437321;
  localparam logic [MW-1:0] M0 = 256'h3e18f03ab37b2857e70000;

  vec_t vecs[7];
  vec_t rv;
  int   k;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{P0, Q0, 1'b0, M0,  0,  0, 1'b0, ref_f(P0, Q0, 1'b0, M0), 1'b0,  6, 1, 1, 12, 2, 2, 1'b0};
    vecs[1] = '{P0, Q0, 1'b0, M0,  0,  0, 1'b1, ref_f(P0, Q0, 1'b0, M0), 1'b0,  6, 1, 1, 12, 2, 2, 1'b1};
    vecs[2] = '{~P0, Q0, 1'b1, ~M0, 3,  2, 1'b0, ref_f(~P0, Q0, 1'b1, ~M0), 1'b0, 11, 1, 1, 22, 2, 2, 1'b0};
    vecs[3] = '{P0, Q0, 1'b0, M0, -1,  0, 1'b0, '0, 1'b1, 18, 1, 0, 18, 1, 0, 1'b0};
    vecs[4] = '{P0, Q0, 1'b1, M0,  1, -1, 1'b0, '0, 1'b1, 22, 1, 1, 22, 1, 1, 1'b0};
    vecs[5] = '{P0, ~Q0, 1'b0, M0, 15, 0, 1'b0, ref_f(P0, ~Q0, 1'b0, M0), 1'b0, 21, 1, 1, 42, 2, 2, 1'b0};
    vecs[6] = '{P0, Q0, 1'b0, M0, 16,  0, 1'b0, '0, 1'b1, 18, 1, 0, 18, 1, 0, 1'b0};

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_p = '0; bus.req_q = '0; bus.req_mode = 1'b0; bus.req_msg = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset rsp_valid", bus.rsp_valid, 1'b0);
    chk1("reset ctl_reset_inverter", bus.ctl_reset_inverter, 1'b0);
    chk1("reset ctl_reset_mod_exp", bus.ctl_reset_mod_exp, 1'b0);
    chkw("reset ctl_msg_in", bus.ctl_msg_in, '0);
    chkw("reset rsp_msg", bus.rsp_msg, '0);
    chk1("reset rsp_timeout", bus.rsp_timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("req_ready after reset", bus.req_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_job(vecs[i], (i == 0) ? 5 : i % 3);

    for (int i = 0; i < 16; i++) begin
      rv.p = {4{$urandom}};
      rv.q = {4{$urandom}};
      rv.mode = 1'($urandom_range(0, 1));
      rv.msg = {8{$urandom}};
      rv.d_inv = $urandom_range(0, 6);
      rv.d_exp = $urandom_range(0, 6);
      rv.corrupt = 1'($urandom_range(0, 1));
      rv.exp_msg = ref_f(rv.p, rv.q, rv.mode, rv.msg);
      rv.exp_to = 1'b0;
      rv.lat = 6 + rv.d_inv + rv.d_exp;
      rv.n_inv = 1; rv.n_exp = 1;
      rv.lat_c = 12 + 2 * (rv.d_inv + rv.d_exp);
      rv.n_inv_c = 2; rv.n_exp_c = 2;
      rv.mm_c = rv.corrupt;
      run_job(rv, $urandom_range(0, 3));
    end

    // finish flags already high when the job starts must not count in the blanking cycle
    manual = 1'b1; man_inv = 1'b1; man_exp = 1'b1; man_msg = {8{$urandom}};
    inv_delay = 0; exp_delay = 0; corrupt = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_p = P0; bus.req_q = Q0; bus.req_mode = 1'b0; bus.req_msg = M0;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    chk1("stale inv pulse", bus.ctl_reset_inverter, 1'b1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk1("stale inv blanked", bus.ctl_reset_mod_exp, 1'b0);
    man_inv = 1'b0;
    @(posedge clk); @(negedge clk);
    chk1("stale inv no finish", bus.ctl_reset_mod_exp, 1'b0);
    man_inv = 1'b1;
    @(posedge clk); @(negedge clk);
    chk1("stale inv advance", bus.ctl_reset_mod_exp, 1'b1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
`ifdef RSA_ROUNDTRIP_CHECK_EN
    chk1("stale exp blanked", bus.ctl_reset_inverter, 1'b0);
`else
    chk1("stale exp blanked", bus.rsp_valid, 1'b0);
`endif
    @(posedge clk); @(negedge clk);
`ifdef RSA_ROUNDTRIP_CHECK_EN
    chk1("stale exp advance", bus.ctl_reset_inverter, 1'b1);
    manual = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 100) begin @(posedge clk); k++; @(negedge clk); end
`endif
    chk1("stale rsp_valid", bus.rsp_valid, 1'b1);
    chkw("stale rsp_msg", bus.rsp_msg, man_msg);
    manual = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk1("stale handshake", bus.req_ready, 1'b1);

    // reset in the middle of EXP_WAIT abandons the job
    inv_delay = 0; exp_delay = 10; corrupt = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_p = P0; bus.req_q = Q0; bus.req_mode = 1'b1; bus.req_msg = M0;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.ctl_reset_mod_exp && k < 30) begin @(posedge clk); k++; @(negedge clk); end
    chk1("mid-job exp pulse seen", bus.ctl_reset_mod_exp, 1'b1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("mid reset rsp_valid", bus.rsp_valid, 1'b0);
    chk1("mid reset ctl_reset_mod_exp", bus.ctl_reset_mod_exp, 1'b0);
    chk1("mid reset ctl_reset_inverter", bus.ctl_reset_inverter, 1'b0);
    chkw("mid reset ctl_p", {{W{1'b0}}, bus.ctl_p}, '0);
    chkw("mid reset ctl_msg_in", bus.ctl_msg_in, '0);
    chk1("mid reset ctl_encrypt_decrypt", bus.ctl_encrypt_decrypt, 1'b0);
    chkw("mid reset rsp_msg", bus.rsp_msg, '0);
    chk1("mid reset rsp_timeout", bus.rsp_timeout, 1'b0);
`ifdef RSA_ROUNDTRIP_CHECK_EN
    chk1("mid reset rsp_mismatch", bus.rsp_mismatch, 1'b0);
`endif
    @(posedge clk); @(posedge clk);
    #1;
    chk1("in reset rsp_valid", bus.rsp_valid, 1'b0);
    rst_n = 1'b1;
    run_job(vecs[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rsa_job_sequencer.md
RSA_JOB_SEQUENCER -- requirements
Module: rsa_job_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128: prime operand width; message width is 2*WIDTH.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum cycles allowed in any finish-wait state.
REQ-003 The block SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1: job request valid.
REQ-006 The block SHALL have port req_ready, output, 1: sequencer accepts a job.
REQ-007 The block SHALL have ports req_p and req_q, input, WIDTH each: primes for the job.
REQ-008 The block SHALL have port req_mode, input, 1: encrypt_decrypt select passed to the control block.
REQ-009 The block SHALL have port req_msg, input, 2*WIDTH: message in.
REQ-010 The block SHALL have port rsp_valid, output, 1: result valid.
REQ-011 The block SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-012 The block SHALL have port rsp_msg, output, 2*WIDTH: result message.
REQ-013 The block SHALL have port rsp_timeout, output, 1: job aborted on timeout.
REQ-014 The block SHALL have ports ctl_p and ctl_q, output, WIDTH each; ctl_encrypt_decrypt, output, 1; and ctl_msg_in, output, 2*WIDTH: operands to the RSA control block.
REQ-015 The block SHALL have ports ctl_reset_inverter and ctl_reset_mod_exp, output, 1 each: active-high start pulses to the control block.
REQ-016 The block SHALL have ports ctl_inverter_finish and ctl_mod_exp_finish, input, 1 each; and ctl_msg_out, input, 2*WIDTH: status and result from the control block.

Function
REQ-017 The FSM SHALL have states IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT, RESP, plus CHK_INV_PULSE, CHK_INV_WAIT, CHK_EXP_PULSE, CHK_EXP_WAIT when the check feature is compiled in.
REQ-018 req_ready SHALL be 1 only in IDLE; a job SHALL be accepted on req_valid&&req_ready, with p, q, mode and msg registered onto the ctl_* operand outputs, and the FSM SHALL then go to INV_PULSE.
REQ-019 ctl_* operand outputs SHALL hold stable from acceptance until the next acceptance.
REQ-020 Each *_PULSE state SHALL last exactly one cycle, asserting the matching ctl_reset_* for that cycle only, then enter the matching *_WAIT state.
REQ-021 Each *_WAIT state SHALL ignore finish in its first cycle (stale-finish blanking), then advance on the first cycle the matching finish is sampled 1: INV_WAIT->EXP_PULSE, EXP_WAIT->RESP (or CHK_INV_PULSE when the check is enabled).
REQ-022 On the EXP_WAIT exit, ctl_msg_out SHALL be captured into rsp_msg in that same cycle.
REQ-023 A 32-bit wait counter SHALL clear on entry to each *_WAIT state; when it reaches TIMEOUT_CYCLES without finish, the FSM SHALL go to RESP with rsp_timeout=1 and rsp_msg=0.
REQ-024 In RESP, rsp_valid SHALL be 1, with rsp_msg, rsp_timeout and rsp_mismatch held stable until rsp_ready; on rsp_valid&&rsp_ready the FSM SHALL return to IDLE and clear rsp_valid in the next cycle.
REQ-025 Latency from acceptance to rsp_valid SHALL be 6 cycles plus the two control-block finish delays, or 12 cycles plus the four delays when the check is enabled.
REQ-026 req_valid SHALL be ignored in all states other than IDLE.

Reset
REQ-027 While rst_n=0 the block SHALL immediately force FSM=IDLE, counter=0, and all outputs (req_ready excepted) to 0; req_ready SHALL be 1 after reset release.
REQ-028 A reset asserted mid-job SHALL abandon the job with no response; the first cycle after release SHALL accept a new job.

Configuration
REQ-029 With macro RSA_ROUNDTRIP_CHECK_EN defined, after capture the FSM SHALL rerun the control block through CHK_* states, with ctl_msg_in=captured rsp_msg, ctl_encrypt_decrypt=~req_mode and the same p and q, then set output rsp_mismatch (1 bit) = (ctl_msg_out != original req_msg); timeout rules SHALL also apply in the CHK_* waits.
REQ-030 Without RSA_ROUNDTRIP_CHECK_EN, the CHK_* states and the rsp_mismatch port SHALL NOT exist, and EXP_WAIT SHALL go directly to RESP.

Verification
REQ-031 The bench SHALL cover: p=113680897410347, q=7999808077935876437321, mode=0, msg=0x3e18f03ab37b2857e70000 -> exactly one ctl_reset_inverter and one ctl_reset_mod_exp pulse of 1 cycle each, and rsp_msg equal to ctl_msg_out at mod_exp_finish.
REQ-032 The bench SHALL cover: same job with RSA_ROUNDTRIP_CHECK_EN -> rsp_mismatch=0; control model corrupting bit 0 on the second pass -> rsp_mismatch=1.
REQ-033 The bench SHALL cover: TIMEOUT_CYCLES=16 with a stub that never raises inverter_finish -> rsp_valid after 2+16 cycles post-acceptance, rsp_timeout=1, rsp_msg=0, and no ctl_reset_mod_exp pulse.
REQ-034 The bench SHALL cover: ctl_inverter_finish held 1 from the previous job -> no advance in the blanking cycle; advance only on a finish sampled after blanking.
REQ-035 The bench SHALL cover: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_msg stable, req_ready=0 throughout; req_ready=1 the cycle after the handshake.
REQ-036 The bench SHALL cover: rst_n pulsed low during EXP_WAIT -> all outputs 0 immediately, no rsp_valid, next job completes normally.
